// File: rtl/sr_using_tff.sv
// Clocked SR flip-flop: a T flip-flop core fed by SR-to-T conversion logic.
// Synchronous active-high clear loads RESET_VAL; outputs are the registered state and its complement.
module sr_using_tff #(
  parameter logic RESET_VAL    = 1'b0,
  parameter int   SR_BOTH_MODE = 0
) (
  input  logic clk,
  input  logic clr,
  input  logic s,
  input  logic r,
  output logic qsr,
  output logic qsrbar
);

  logic q_q;
  logic q_d;
  logic t;

  // SR-to-T conversion; s=r=1 either holds (T=0) or keeps the raw toggle (T=1).
  always_comb begin
    t = (s & ~q_q) | (r & q_q);
    if (s && r) begin
      t = (SR_BOTH_MODE != 0);
    end
    q_d = q_q ^ t;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign qsr    = q_q;
  assign qsrbar = ~q_q;

endmodule

// File: tb/tb_sr_using_tff.sv
// Bench for sr_using_tff: two instances (hold-on-both / toggle-on-both) driven by shared
// inputs and compared against a next-state table model.
module tb_sr_using_tff;

  logic clk = 1'b0;
  logic clr;
  logic s;
  logic r;
  logic qsr0, qsrbar0;
  logic qsr1, qsrbar1;

  int tests = 0;
  int fails = 0;

  logic exp0;
  logic exp1;

  always #10 clk = ~clk;

  sr_using_tff #(.RESET_VAL(1'b0), .SR_BOTH_MODE(0)) dut0 (
    .clk(clk), .clr(clr), .s(s), .r(r), .qsr(qsr0), .qsrbar(qsrbar0)
  );

  sr_using_tff #(.RESET_VAL(1'b1), .SR_BOTH_MODE(1)) dut1 (
    .clk(clk), .clr(clr), .s(s), .r(r), .qsr(qsr1), .qsrbar(qsrbar1)
  );

  // Next-state table of an SR flip-flop with synchronous clear.
  function automatic logic model_next(input logic q, input logic si, input logic ri,
                                      input logic ci, input logic rst_val, input bit both_toggle);
    if (ci) return rst_val;
    case ({si, ri})
      2'b10:   return 1'b1;
      2'b01:   return 1'b0;
      2'b11:   return both_toggle ? ~q : q;
      default: return q;
    endcase
  endfunction

  task automatic check(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_qsr_m0"},    qsr0,    exp0);
    check({tag, "_qsrbar_m0"}, qsrbar0, ~exp0);
    check({tag, "_qsr_m1"},    qsr1,    exp1);
    check({tag, "_qsrbar_m1"}, qsrbar1, ~exp1);
  endtask

  // Drive inputs, let one rising edge sample them, then compare on the falling edge.
  task automatic step(input string tag, input logic si, input logic ri, input logic ci);
    s   = si;
    r   = ri;
    clr = ci;
    @(posedge clk);
    exp0 = model_next(exp0, si, ri, ci, 1'b0, 1'b0);
    exp1 = model_next(exp1, si, ri, ci, 1'b1, 1'b1);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic si, ri, ci;
    exp0 = 1'bx;
    exp1 = 1'bx;

    // Reset held for two edges, then released.
    step("reset1", 1'b0, 1'b0, 1'b1);
    step("reset2", 1'b0, 1'b0, 1'b1);
    step("reset_release", 1'b0, 1'b0, 1'b0);
    check("reset_abs_m0", qsr0, 1'b0);

    // Set, then hold set while s stays high.
    step("set", 1'b1, 1'b0, 1'b0);
    check("set_abs_m0", qsr0, 1'b1);
    step("set_hold", 1'b1, 1'b0, 1'b0);

    // Clear, then idle for three edges.
    step("clear", 1'b0, 1'b1, 1'b0);
    check("clear_abs_m0", qsr0, 1'b0);
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 1'b0);
    step("clear_again", 1'b0, 1'b1, 1'b0);

    // Both asserted from q=1: hold on m0, toggle 1->0->1 on m1.
    step("pre_both", 1'b1, 1'b0, 1'b0);
    step("both1", 1'b1, 1'b1, 1'b0);
    check("both1_abs_m1", qsr1, 1'b0);
    step("both2", 1'b1, 1'b1, 1'b0);
    check("both2_abs_m0", qsr0, 1'b1);
    check("both2_abs_m1", qsr1, 1'b1);

    // clr glitch between edges has no effect.
    s = 1'b1; r = 1'b0; clr = 1'b1;
    #3 clr = 1'b0;
    step("clr_glitch", 1'b1, 1'b0, 1'b0);
    check("clr_glitch_abs_m0", qsr0, 1'b1);

    // clr across an edge wins over s, and holds while asserted.
    step("clr_prio1", 1'b1, 1'b0, 1'b1);
    check("clr_prio_abs_m0", qsr0, 1'b0);
    step("clr_prio2", 1'b1, 1'b0, 1'b1);
    step("clr_prio_rel", 1'b0, 1'b0, 1'b0);

    // Random traffic with occasional clear.
    for (int i = 0; i < 200; i++) begin
      si = 1'($urandom_range(0, 1));
      ri = 1'($urandom_range(0, 1));
      ci = ($urandom_range(0, 15) == 0);
      step("random", si, ri, ci);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
